// File: rtl/morse_symbol_decoder_if.sv
// ---------------------------------------------------------------------------
// morse_symbol_decoder_if
//   Output handshake bundle of the Morse symbol decoder. The decoder drives
//   the head FIFO entry through the master modport. The consumer drives
//   out_ready through the slave modport.
//
//   out_valid  head entry present
//   out_ready  consumer accepts head entry
//   out_code   symbols, bit i = symbol i (first symbol in bit 0), 1 = dash
//   out_len    symbol count, 0 for a word-break entry
//   out_space  entry is a word break
//   out_err    letter had more than MAX_SYM symbols
// ---------------------------------------------------------------------------
interface morse_symbol_decoder_if #(
    parameter int MAX_SYM = 6
);
    localparam int LEN_W = $clog2(MAX_SYM + 1);

    logic               out_valid;
    logic               out_ready;
    logic [MAX_SYM-1:0] out_code;
    logic [LEN_W-1:0]   out_len;
    logic               out_space;
    logic               out_err;

    modport master (
        output out_valid,
        output out_code,
        output out_len,
        output out_space,
        output out_err,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_code,
        input  out_len,
        input  out_space,
        input  out_err,
        output out_ready
    );
endinterface

// File: rtl/morse_symbol_decoder.sv
// ---------------------------------------------------------------------------
// morse_symbol_decoder
//   Morse front-end. It synchronises and debounces the raw key line. A single
//   counter times marks and spaces. Marks are classified as dot or dash, and
//   each letter is assembled as a code/length pair. Letters and word breaks
//   are queued in a show-ahead FIFO that is drained over a valid/ready
//   handshake.
//
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   morse       raw asynchronous key level, 1 = mark
//   out_if      head-entry handshake (master modport)
//   overrun     sticky; an entry was dropped because the FIFO was full
//   fifo_count  occupied FIFO entries
// ---------------------------------------------------------------------------
module morse_symbol_decoder #(
    parameter int CNT_W      = 16,
    parameter int DEBOUNCE   = 2,
    parameter int DOT_MAX    = 60,
    parameter int LETTER_GAP = 200,
    parameter int WORD_GAP   = 600,
    parameter int MAX_SYM    = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              morse,
    morse_symbol_decoder_if.master            out_if,
    output logic                              overrun,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);
    localparam int LEN_W = $clog2(MAX_SYM + 1);
    localparam int DB_W  = $clog2(DEBOUNCE + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = MAX_SYM + LEN_W + 2;

    localparam logic [CNT_W-1:0] DOT_MAX_C    = CNT_W'(DOT_MAX);
    localparam logic [CNT_W-1:0] LETTER_GAP_C = CNT_W'(LETTER_GAP);
    localparam logic [CNT_W-1:0] WORD_GAP_C   = CNT_W'(WORD_GAP);
    localparam logic [LEN_W-1:0] MAX_SYM_C    = LEN_W'(MAX_SYM);
    localparam logic [DB_W-1:0]  DB_LAST_C    = DB_W'(DEBOUNCE - 1);
    localparam logic [CW-1:0]    DEPTH_C      = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MARK  = 2'd1;
    localparam logic [1:0] S_SPACE = 2'd2;

    // ------------------------------------------------------------------
    // Synchroniser and debouncer
    // ------------------------------------------------------------------
    logic            sync1_q, sync2_q;
    logic            key_q, key_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;

    // key follows sync2 only after DEBOUNCE consecutive differing cycles.
    // Any cycle of agreement restarts the count.
    always_comb begin
        key_d    = key_q;
        db_cnt_d = '0;
        if (sync2_q != key_q) begin
            if (db_cnt_q == DB_LAST_C) begin
                key_d = sync2_q;
            end else begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            key_q    <= 1'b0;
            db_cnt_q <= '0;
        end else begin
            sync1_q  <= morse;
            sync2_q  <= sync1_q;
            key_q    <= key_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Timing FSM and letter accumulator
    // ------------------------------------------------------------------
    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   dur_q, dur_d, dur_inc;
    logic [MAX_SYM-1:0] code_q, code_d;
    logic [LEN_W-1:0]   sym_cnt_q, sym_cnt_d;
    logic               too_long_q, too_long_d;
    logic               push;
    logic [ENT_W-1:0]   push_entry;
    logic               is_dash;

    // dur_inc is the length of the current state including this cycle.
    // It is 1 in the first cycle after entry, and marks and gaps are
    // compared against it.
    assign dur_inc = (dur_q == '1) ? dur_q : dur_q + CNT_W'(1);
    assign is_dash = (dur_inc > DOT_MAX_C);

    always_comb begin
        state_d    = state_q;
        dur_d      = dur_q;
        code_d     = code_q;
        sym_cnt_d  = sym_cnt_q;
        too_long_d = too_long_q;
        push       = 1'b0;
        push_entry = '0;
        unique case (state_q)
            S_MARK: begin
                dur_d = dur_inc;
                if (!key_q) begin
                    if (sym_cnt_q < MAX_SYM_C) begin
                        for (int unsigned i = 0; i < MAX_SYM; i++) begin
                            if (LEN_W'(i) == sym_cnt_q) begin
                                code_d[i] = is_dash;
                            end
                        end
                        sym_cnt_d = sym_cnt_q + LEN_W'(1);
                    end else begin
                        too_long_d = 1'b1;
                    end
                    state_d = S_SPACE;
                    dur_d   = '0;
                end
            end
            S_SPACE: begin
                dur_d = dur_inc;
                // A gap threshold is handled before a key rise in the same
                // cycle. The letter or break is pushed first, and the rise
                // then starts a fresh mark.
                if (dur_inc == LETTER_GAP_C) begin
                    push       = 1'b1;
                    push_entry = {code_q, sym_cnt_q, 1'b0, too_long_q};
                    code_d     = '0;
                    sym_cnt_d  = '0;
                    too_long_d = 1'b0;
                end
                if (dur_inc == WORD_GAP_C) begin
                    push       = 1'b1;
                    push_entry = {{MAX_SYM{1'b0}}, {LEN_W{1'b0}}, 1'b1, 1'b0};
                    state_d    = S_IDLE;
                    dur_d      = '0;
                end
                if (key_q) begin
                    state_d = S_MARK;
                    dur_d   = '0;
                end
            end
            default: begin
                dur_d = '0;
                if (key_q) begin
                    state_d = S_MARK;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            dur_q      <= '0;
            code_q     <= '0;
            sym_cnt_q  <= '0;
            too_long_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            dur_q      <= dur_d;
            code_q     <= code_d;
            sym_cnt_q  <= sym_cnt_d;
            too_long_q <= too_long_d;
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead output FIFO, entry layout {code, len, space, err}
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic             overrun_q;
    logic             valid, full, pop, push_ok;
    logic [ENT_W-1:0] head;

    assign valid   = (count_q != '0);
    assign full    = (count_q == DEPTH_C);
    assign pop     = valid && out_if.out_ready;
    // A push into a full FIFO is still accepted when the head leaves in the
    // same cycle.
    assign push_ok = push && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_entry;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !push_ok) begin
                overrun_q <= 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign head             = valid ? mem_q[rd_ptr_q] : '0;
    assign out_if.out_valid = valid;
    assign out_if.out_code  = head[ENT_W-1 -: MAX_SYM];
    assign out_if.out_len   = head[LEN_W+1 -: LEN_W];
    assign out_if.out_space = head[1];
    assign out_if.out_err   = head[0];
    assign overrun          = overrun_q;
    assign fifo_count       = count_q;

endmodule
